// File: rtl/sccb_master_rw.sv
// SCCB master for register writes (3-phase) and reads (2-phase write + 2-phase read).
// Every bit is a slot of four quarters; SCL and the SDA pull-down are decoded from state/quarter.
module sccb_master_rw #(
    parameter int unsigned CLK_DIV   = 250,
    parameter bit          ADDR16    = 1'b1,
    parameter logic [7:0]  DEV_ID    = 8'h78,
    parameter bit          ACK_CHECK = 1'b0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    input  logic        rw,
    input  logic [15:0] reg_addr,
    input  logic [7:0]  wr_data,
    output logic        busy,
    output logic        done,
    output logic [7:0]  rd_data,
    output logic        nack,
    output logic        scl,
    output logic        sda_oe,
    input  logic        sda_i
);
    localparam int unsigned   CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] QMAX = CW'(CLK_DIV - 1);

    typedef enum logic [3:0] {
        StIdle, StStart, StId, StAddrH, StAddrL, StWData,
        StStop1, StRestart, StRId, StRData, StStop
    } state_t;

    state_t        r_state, w_state_d;
    logic [CW-1:0] r_qcnt, w_qcnt_d;
    logic [1:0]    r_quarter, w_quarter_d;
    logic [3:0]    r_bit, w_bit_d;
    logic          r_rw, w_rw_d;
    logic [15:0]   r_addr, w_addr_d;
    logic [7:0]    r_wdata, w_wdata_d;
    logic [7:0]    r_rx, w_rx_d;
    logic          r_rx_ok, w_rx_ok_d;
    logic [7:0]    r_rd_data, w_rd_data_d;
    logic          r_nack, w_nack_d;
    logic          r_ack_bad, w_ack_bad_d;
    logic          r_done, w_done_d;

    logic       w_tick, w_slot_end, w_sample, w_accept, w_last_bit, w_abort;
    logic       w_is_byte, w_slave_ack, w_txbit;
    logic [7:0] w_byte;

    assign w_tick      = (r_state != StIdle) && (r_qcnt == QMAX);
    assign w_slot_end  = w_tick && (r_quarter == 2'd3);
    assign w_sample    = w_tick && (r_quarter == 2'd1);
    assign w_accept    = (r_state == StIdle) && start && !r_done;
    assign w_last_bit  = (r_bit == 4'd8);
    assign w_abort     = ACK_CHECK && r_ack_bad;
    assign w_slave_ack = w_is_byte && (r_state != StRData);
    assign w_txbit     = w_byte[3'd7 - r_bit[2:0]];

    // Read data bytes shift out all ones so the master simply releases SDA.
    always_comb begin
        w_byte    = 8'hFF;
        w_is_byte = 1'b1;
        case (r_state)
            StId:    w_byte = {DEV_ID[7:1], 1'b0};
            StAddrH: w_byte = r_addr[15:8];
            StAddrL: w_byte = r_addr[7:0];
            StWData: w_byte = r_wdata;
            StRId:   w_byte = {DEV_ID[7:1], 1'b1};
            StRData: w_byte = 8'hFF;
            default: w_is_byte = 1'b0;
        endcase
    end

    always_comb begin
        scl    = 1'b1;
        sda_oe = 1'b0;
        case (r_state)
            StIdle: begin
            end
            StStart, StRestart: begin
                sda_oe = r_quarter[1];
                scl    = (r_quarter != 2'd3);
            end
            StStop1, StStop: begin
                sda_oe = ~r_quarter[1];
                scl    = (r_quarter != 2'd0);
            end
            default: begin
                sda_oe = ~w_last_bit & ~w_txbit;
                scl    = (r_quarter == 2'd1) || (r_quarter == 2'd2);
            end
        endcase
    end

    always_comb begin
        w_state_d   = r_state;
        w_qcnt_d    = r_qcnt;
        w_quarter_d = r_quarter;
        w_bit_d     = r_bit;
        w_rw_d      = r_rw;
        w_addr_d    = r_addr;
        w_wdata_d   = r_wdata;
        w_rx_d      = r_rx;
        w_rx_ok_d   = r_rx_ok;
        w_rd_data_d = r_rd_data;
        w_nack_d    = r_nack;
        w_ack_bad_d = r_ack_bad;
        w_done_d    = 1'b0;
        if (w_accept) begin
            w_state_d   = StStart;
            w_qcnt_d    = '0;
            w_quarter_d = 2'd0;
            w_bit_d     = 4'd0;
            w_rw_d      = rw;
            w_addr_d    = reg_addr;
            w_wdata_d   = wr_data;
            w_rx_ok_d   = 1'b0;
            w_nack_d    = 1'b0;
            w_ack_bad_d = 1'b0;
        end else if (r_state != StIdle) begin
            w_qcnt_d = w_tick ? '0 : r_qcnt + 1'b1;
            if (w_tick) begin
                w_quarter_d = r_quarter + 2'd1;
            end
            if (w_sample && w_slave_ack && w_last_bit) begin
                w_nack_d    = r_nack | sda_i;
                w_ack_bad_d = sda_i;
            end
            if (w_sample && (r_state == StRData) && !w_last_bit) begin
                w_rx_d = {r_rx[6:0], sda_i};
            end
            if (w_slot_end) begin
                if (w_is_byte && !w_last_bit) begin
                    w_bit_d = r_bit + 4'd1;
                end else begin
                    w_bit_d = 4'd0;
                    case (r_state)
                        StStart:   w_state_d = StId;
                        StId:      w_state_d = w_abort ? StStop : (ADDR16 ? StAddrH : StAddrL);
                        StAddrH:   w_state_d = w_abort ? StStop : StAddrL;
                        StAddrL:   w_state_d = w_abort ? StStop : (r_rw ? StStop1 : StWData);
                        StWData:   w_state_d = StStop;
                        StStop1:   w_state_d = StRestart;
                        StRestart: w_state_d = StRId;
                        StRId:     w_state_d = w_abort ? StStop : StRData;
                        StRData: begin
                            w_state_d = StStop;
                            w_rx_ok_d = 1'b1;
                        end
                        StStop: begin
                            w_state_d = StIdle;
                            w_done_d  = 1'b1;
                            if (r_rx_ok) begin
                                w_rd_data_d = r_rx;
                            end
                        end
                        default:   w_state_d = StIdle;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state   <= StIdle;
            r_qcnt    <= '0;
            r_quarter <= 2'd0;
            r_bit     <= 4'd0;
            r_rw      <= 1'b0;
            r_addr    <= 16'h0000;
            r_wdata   <= 8'h00;
            r_rx      <= 8'h00;
            r_rx_ok   <= 1'b0;
            r_rd_data <= 8'h00;
            r_nack    <= 1'b0;
            r_ack_bad <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_qcnt    <= w_qcnt_d;
            r_quarter <= w_quarter_d;
            r_bit     <= w_bit_d;
            r_rw      <= w_rw_d;
            r_addr    <= w_addr_d;
            r_wdata   <= w_wdata_d;
            r_rx      <= w_rx_d;
            r_rx_ok   <= w_rx_ok_d;
            r_rd_data <= w_rd_data_d;
            r_nack    <= w_nack_d;
            r_ack_bad <= w_ack_bad_d;
            r_done    <= w_done_d;
        end
    end

    assign busy    = (r_state != StIdle);
    assign done    = r_done;
    assign rd_data = r_rd_data;
    assign nack    = r_nack;

endmodule

// File: tb/tb_sccb_master_rw.sv
// Bench for sccb_master_rw: three configurations share one behavioural SCCB slave via a bus mux.
module tb_sccb_master_rw;
    localparam int unsigned CLK_DIV = 4;
    localparam int M_START = 256;
    localparam int M_STOP  = 512;
    localparam int M_NA    = 768;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn, start, rw;
    logic [15:0] reg_addr;
    logic [7:0]  wr_data;
    logic [1:0]  sel;
    logic [2:0]  busy_v, done_v, nack_v, scl_v, oe_v;
    logic [7:0]  rd_a, rd_b, rd_c;
    logic        bus_scl, bus_oe, sda_line, slv_oe;
    logic        busy_m, done_m, nack_m;
    logic [7:0]  rd_m;
    logic        nack_first;
    logic [7:0]  rd_val;

    int n_err, n_chk;
    int got[$];
    int exp_q[$];

    assign bus_scl  = scl_v[sel];
    assign bus_oe   = oe_v[sel];
    assign sda_line = ~(bus_oe | slv_oe);
    assign busy_m   = busy_v[sel];
    assign done_m   = done_v[sel];
    assign nack_m   = nack_v[sel];
    assign rd_m     = (sel == 2'd0) ? rd_a : ((sel == 2'd1) ? rd_b : rd_c);

    sccb_master_rw #(.CLK_DIV(CLK_DIV), .ADDR16(1'b0), .DEV_ID(8'h78), .ACK_CHECK(1'b0)) u_dut_a (
        .clk(clk), .rstn(rstn), .start(start && (sel == 2'd0)), .rw(rw), .reg_addr(reg_addr),
        .wr_data(wr_data), .busy(busy_v[0]), .done(done_v[0]), .rd_data(rd_a), .nack(nack_v[0]),
        .scl(scl_v[0]), .sda_oe(oe_v[0]), .sda_i(sda_line)
    );
    sccb_master_rw #(.CLK_DIV(CLK_DIV), .ADDR16(1'b1), .DEV_ID(8'h78), .ACK_CHECK(1'b0)) u_dut_b (
        .clk(clk), .rstn(rstn), .start(start && (sel == 2'd1)), .rw(rw), .reg_addr(reg_addr),
        .wr_data(wr_data), .busy(busy_v[1]), .done(done_v[1]), .rd_data(rd_b), .nack(nack_v[1]),
        .scl(scl_v[1]), .sda_oe(oe_v[1]), .sda_i(sda_line)
    );
    sccb_master_rw #(.CLK_DIV(CLK_DIV), .ADDR16(1'b0), .DEV_ID(8'h78), .ACK_CHECK(1'b1)) u_dut_c (
        .clk(clk), .rstn(rstn), .start(start && (sel == 2'd2)), .rw(rw), .reg_addr(reg_addr),
        .wr_data(wr_data), .busy(busy_v[2]), .done(done_v[2]), .rd_data(rd_c), .nack(nack_v[2]),
        .scl(scl_v[2]), .sda_oe(oe_v[2]), .sda_i(sda_line)
    );

    // Slave: logs START/STOP/bytes/master-NA, acks written bytes, returns rd_val after a read ID.
    initial begin : slave
        logic       ps, pd, cs, cd, reading, go_read, skip_fall;
        int         bitcnt, byte_no;
        logic [7:0] sh;
        ps = 1'b1; pd = 1'b1; reading = 1'b0; go_read = 1'b0; skip_fall = 1'b0;
        bitcnt = 0; byte_no = 0; sh = 8'h00; slv_oe = 1'b0;
        forever begin
            @(negedge clk);
            cs = bus_scl;
            cd = sda_line;
            if (ps && cs && pd && !cd) begin
                got.push_back(M_START);
                bitcnt = 0; byte_no = 0; reading = 1'b0; go_read = 1'b0;
                skip_fall = 1'b1; slv_oe = 1'b0;
            end else if (ps && cs && !pd && cd) begin
                got.push_back(M_STOP);
                slv_oe = 1'b0; reading = 1'b0;
            end else if (!ps && cs) begin
                if (bitcnt < 8) sh = {sh[6:0], cd};
                else if (reading) got.push_back(M_NA | int'(cd));
            end else if (ps && !cs) begin
                if (skip_fall) begin
                    skip_fall = 1'b0;
                end else if (bitcnt == 8) begin
                    bitcnt = 0;
                    slv_oe = 1'b0;
                    if (reading) begin
                        reading = 1'b0;
                    end else if (go_read) begin
                        reading = 1'b1; go_read = 1'b0; slv_oe = ~rd_val[7];
                    end
                end else begin
                    bitcnt++;
                    if (bitcnt == 8) begin
                        if (reading) begin
                            slv_oe = 1'b0;
                        end else begin
                            got.push_back(int'(sh));
                            slv_oe = !(nack_first && (byte_no == 0));
                            if (byte_no == 0 && sh[0]) go_read = 1'b1;
                            byte_no++;
                        end
                    end else if (reading) begin
                        slv_oe = ~rd_val[3'(7 - bitcnt)];
                    end
                end
            end
            ps = cs;
            pd = cd;
        end
    end

    typedef struct {
        logic [1:0]  sel;
        logic        rw;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic        nack_id;
        logic [7:0]  rd_val;
        int          lat;
        logic        exp_nack;
        logic [7:0]  exp_rd;
    } vec_t;
    vec_t vecs [11];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (sel=%0d, t=%0t)", name, act, exp, sel, $time);
        end
    endtask

    // Expected bus trace; only the ACK_CHECK instance (sel 2) cuts the transfer short.
    task automatic build_exp(input vec_t v);
        exp_q.delete();
        exp_q.push_back(M_START);
        exp_q.push_back(32'h78);
        if (v.nack_id && v.sel == 2'd2) begin
            exp_q.push_back(M_STOP);
            return;
        end
        if (v.sel == 2'd1) exp_q.push_back(int'(v.addr[15:8]));
        exp_q.push_back(int'(v.addr[7:0]));
        if (!v.rw) begin
            exp_q.push_back(int'(v.wdata));
            exp_q.push_back(M_STOP);
        end else begin
            exp_q.push_back(M_STOP);
            exp_q.push_back(M_START);
            exp_q.push_back(32'h79);
            exp_q.push_back(M_NA | 1);
            exp_q.push_back(M_STOP);
        end
    endtask

    task automatic cmp_bus();
        bit    ok;
        string sg, se;
        ok = (got.size() == exp_q.size());
        if (ok) foreach (exp_q[k]) if (got[k] != exp_q[k]) ok = 1'b0;
        n_chk++;
        if (!ok) begin
            n_err++;
            sg = ""; se = "";
            foreach (got[k]) sg = {sg, $sformatf(" %0h", got[k])};
            foreach (exp_q[k]) se = {se, $sformatf(" %0h", exp_q[k])};
            $display("FAIL bus_seq: got [%s ] expected [%s ]", sg, se);
        end
    endtask

    task automatic run_vec(input vec_t v, input bit poke);
        int lat;
        bit seen, saw_busy;
        sel = v.sel; nack_first = v.nack_id; rd_val = v.rd_val;
        @(negedge clk);
        got.delete();
        rw = v.rw; reg_addr = v.addr; wr_data = v.wdata; start = 1'b1;
        @(posedge clk);
        lat = 1; seen = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (i == 0) chk("busy_rise", int'(busy_m), 1);
            if (done_m) begin
                seen = 1'b1;
                break;
            end
            if (poke && lat == 50) begin
                start = 1'b1; reg_addr = 16'h00EE;
            end
            @(posedge clk);
            lat++;
        end
        chk("done_seen", int'(seen), 1);
        chk("latency", lat, v.lat);
        chk("nack", int'(nack_m), int'(v.exp_nack));
        chk("rd_data", int'(rd_m), int'(v.exp_rd));
        if (poke) start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_pulse_busy_low", int'({busy_m, done_m}), 0);
        if (poke) begin
            saw_busy = 1'b0;
            repeat (100) begin
                @(negedge clk);
                if (busy_m) saw_busy = 1'b1;
            end
            chk("no_retrigger", int'(saw_busy), 0);
        end
        build_exp(v);
        cmp_bus();
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        n_err = 0; n_chk = 0;
        sel = 2'd0; start = 1'b0; rw = 1'b0; reg_addr = 16'h0; wr_data = 8'h0; rstn = 1'b0;
        nack_first = 1'b0; rd_val = 8'h00;
        vecs[0]  = '{2'd0, 1'b0, 16'h003C, 8'hA5, 1'b0, 8'h00, 465, 1'b0, 8'h00};
        vecs[1]  = '{2'd1, 1'b1, 16'h300A, 8'h00, 1'b0, 8'h56, 785, 1'b0, 8'h56};
        vecs[2]  = '{2'd1, 1'b0, 16'h1234, 8'h5A, 1'b0, 8'h00, 609, 1'b0, 8'h56};
        vecs[3]  = '{2'd2, 1'b0, 16'h003C, 8'hA5, 1'b1, 8'h00, 177, 1'b1, 8'h00};
        vecs[4]  = '{2'd0, 1'b0, 16'h003C, 8'hA5, 1'b1, 8'h00, 465, 1'b1, 8'h00};
        vecs[5]  = '{2'd2, 1'b1, 16'h0021, 8'h00, 1'b1, 8'hC3, 177, 1'b1, 8'h00};
        vecs[6]  = '{2'd2, 1'b1, 16'h0055, 8'h00, 1'b0, 8'h44, 641, 1'b0, 8'h44};
        vecs[7]  = '{2'd2, 1'b1, 16'h0066, 8'h00, 1'b1, 8'hBB, 177, 1'b1, 8'h44};
        vecs[8]  = '{2'd0, 1'b1, 16'h0012, 8'h00, 1'b0, 8'h9C, 641, 1'b0, 8'h9C};
        vecs[9]  = '{2'd0, 1'b0, 16'h0020, 8'h11, 1'b0, 8'h00, 465, 1'b0, 8'h9C};
        vecs[10] = '{2'd0, 1'b0, 16'h0010, 8'hC3, 1'b0, 8'h00, 465, 1'b0, 8'h00};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int s = 0; s < 3; s++) begin
            sel = 2'(s);
            #1;
            chk("rst_busy", int'(busy_m), 0);
            chk("rst_done", int'(done_m), 0);
            chk("rst_nack", int'(nack_m), 0);
            chk("rst_rd_data", int'(rd_m), 0);
            chk("rst_scl", int'(bus_scl), 1);
            chk("rst_sda_oe", int'(bus_oe), 0);
        end

        for (int i = 0; i < 9; i++) run_vec(vecs[i], 1'b0);

        // start during busy (cycle 50) and coincident with done must both be dropped
        run_vec(vecs[9], 1'b1);

        // reset in the middle of ADDR_L abandons the transfer and releases the bus
        sel = 2'd0; nack_first = 1'b0;
        @(negedge clk);
        rw = 1'b0; reg_addr = 16'h0044; wr_data = 8'h77; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (231) @(negedge clk);
        chk("busy_before_rst", int'(busy_m), 1);
        rstn = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        chk("rst_mid_scl", int'(bus_scl), 1);
        chk("rst_mid_sda_oe", int'(bus_oe), 0);
        chk("rst_mid_busy", int'(busy_m), 0);
        chk("rst_mid_rd_data", int'(rd_m), 0);
        repeat (5) @(negedge clk);
        run_vec(vecs[10], 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/sccb_master_rw.md
# sccb_master_rw

Parametrised SCCB (camera serial control bus) master that supports write and read register transactions, 8- or 16-bit register addresses, a programmable bit rate and optional ACK checking. It sits between the MicroBlaze-side control logic and the camera's SCCB pins. The external top level resolves the open-drain SDA pad: it drives 0 when `sda_oe`=1 and releases the line otherwise.

## Interface
Parameters:
- `CLK_DIV`, 250: clk cycles per quarter bit-period. Must be ≥2.
- `ADDR16`, 1: 1 sends a 16-bit register address (high byte first); 0 sends an 8-bit address (`reg_addr[7:0]`).
- `DEV_ID`, 8'h78: 8-bit write ID. Bit 0 is replaced by the R/W flag.
- `ACK_CHECK`, 0: 1 aborts to STOP on a slave NACK; 0 ignores NACK (SCCB don't-care bit) and only flags it.

Ports:
- `clk` in 1: system clock.
- `rstn` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle request. Ignored while `busy`=1.
- `rw` in 1: 0 = write, 1 = read. Sampled with `start`.
- `reg_addr` in 16: register address. Sampled with `start`.
- `wr_data` in 8: write data. Sampled with `start`.
- `busy` out 1: high from the cycle after `start` is accepted until `done`.
- `done` out 1: one-cycle pulse at transaction end.
- `rd_data` out 8: last read byte. Updated at `done` of a read that was not aborted.
- `nack` out 1: sticky OR of the slave ack bits in the current transaction. Cleared when `start` is accepted.
- `scl` out 1: SCCB clock.
- `sda_oe` out 1: 1 = pull SDA low.
- `sda_i` in 1: SDA pad level.

## Operation
- Quarter tick: a counter runs 0..CLK_DIV-1 while busy, and a tick fires on wrap. Each slot is 4 quarters, q0..q3.
- Slot waveforms (SDA = released unless driven low):
  - START: q0–q1 SDA=1, SCL=1. q2 SDA=0, SCL=1. q3 SDA=0, SCL=0.
  - Bit: SDA set at q0 with SCL=0. q1–q2 SCL=1. q3 SCL=0. Input is sampled on the clk edge that enters q2.
  - STOP: q0 SDA=0, SCL=0. q1 SDA=0, SCL=1. q2–q3 SDA=1, SCL=1.
- Bytes are sent MSB first, followed by a 9th bit (ack slot).
  - On a slave ack slot the master releases SDA and the sampled value is ORed into `nack`.
  - On a read data byte the master releases SDA for all 9 bits; the 9th bit is the master NA (released, reads 1).
- States: IDLE, START, ID, ADDR_H (only when ADDR16=1), ADDR_L, WDATA, STOP1, RESTART, RID, RDATA, STOP.
- Write sequence: START → ID(DEV_ID&~1) → [ADDR_H] → ADDR_L → WDATA → STOP → IDLE.
- Read sequence: START → ID → [ADDR_H] → ADDR_L → STOP1 → RESTART → RID(DEV_ID|1) → RDATA → STOP → IDLE. This is the SCCB 2-phase write followed by a 2-phase read.
- ACK_CHECK=1 and a sampled ack=1: the remaining bytes are skipped and the next slot is STOP. `done` fires with `nack`=1 and `rd_data` is unchanged.
- Idle state: `scl`=1, `sda_oe`=0, `busy`=0.

## Timing
- Reset values: `busy`=0, `done`=0, `rd_data`=8'h00, `nack`=0, `scl`=1, `sda_oe`=0, state=IDLE, counters=0.
- `start` is accepted in IDLE on a clk edge. `busy`=1 on the next cycle, and the START slot q0 begins on that same cycle.
- Slot counts:
  - Write: 29 slots with ADDR16=0, 38 with ADDR16=1.
  - Read: 40 slots with ADDR16=0, 49 with ADDR16=1.
  - Each slot lasts 4·CLK_DIV cycles.
- `done` pulses on the first cycle after the last STOP q3. `busy` falls in the same cycle. Latency from acceptance = slots·4·CLK_DIV + 1 cycles.
- A `start` arriving in the same cycle as `done`, or while busy, is ignored. A new `start` is accepted from the cycle after `done`.
- `rstn` low mid-transaction: the next edge forces all reset values, which releases the bus. No STOP is generated, and the partial transfer is abandoned.
- `rd_data` and `nack` are stable from `done` until the next accepted `start`.

## Test plan
- CLK_DIV=4, ADDR16=0, write reg 8'h3C, data 8'hA5, slave acks → ID byte 0x78, 0x3C, 0xA5 seen on the bus. `done` arrives 465 cycles after acceptance, `nack`=0.
- CLK_DIV=4, ADDR16=1, read reg 16'h300A with the slave model returning 8'h56 → bytes 0x78, 0x30, 0x0A, STOP, START, 0x79; the master NA bit reads 1; `rd_data`=8'h56 after 785 cycles.
- ACK_CHECK=1, slave NACKs the ID byte of a write → STOP follows immediately after the ID byte (11 slots). `done` arrives after 177 cycles with `nack`=1.
- ACK_CHECK=0, same NACK → the full 29-slot transfer completes with `nack`=1.
- `start` pulsed at cycle 50 of a busy transfer, and again coincident with `done` → both are ignored and no second transaction occurs.
- `rstn` low for 1 cycle at mid-ADDR_L → the next cycle shows `scl`=1, `sda_oe`=0, `busy`=0. A following write completes normally.
